// File: rtl/dma_multi_ch.sv
// dma_multi_ch: multi-channel memory-to-memory DMA with a shared round-robin word engine
module dma_multi_ch #(
  parameter int NUM_CH    = 4,
  parameter int CH_STRIDE = 'h40,
  parameter int LEN_WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [11:0]       s_addr,
  input  logic              s_wen,
  input  logic [63:0]       s_wdata,
  output logic              s_rvalid,
  output logic [63:0]       s_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [63:0]       m_addr,
  output logic              m_wen,
  output logic [63:0]       m_wdata,
  input  logic              m_rvalid,
  input  logic [63:0]       m_rdata,
  output logic [NUM_CH-1:0] irq
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         grant_q, grant_d, last_q, last_d, pick, idx;
  logic                  found, xfer_done, wr;
  logic [63:0]           word_q, word_d, rdata_q, rdata_d;
  logic                  rvalid_q;
  logic [63:0]           src_q [NUM_CH];
  logic [63:0]           src_d [NUM_CH];
  logic [63:0]           dst_q [NUM_CH];
  logic [63:0]           dst_d [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_q [NUM_CH];
  logic [LEN_WIDTH-1:0]  len_d [NUM_CH];
  logic [NUM_CH-1:0]     ien_q, ien_d, busy_q, busy_d, done_q, done_d, err_q, err_d, irq_q;
  logic [11:0]           ch_w, off_w;
  assign ch_w     = s_addr / 12'(CH_STRIDE);
  assign off_w    = s_addr % 12'(CH_STRIDE);
  assign wr       = s_valid && s_wen;
  assign s_ready  = 1'b1;
  assign s_rvalid = rvalid_q;
  assign s_rdata  = rdata_q;
  assign irq      = irq_q;
  assign m_valid  = state_q == RD_REQ || state_q == WR_REQ;
  assign m_wen    = state_q == WR_REQ;
  assign m_addr   = state_q == RD_REQ ? src_q[grant_q] : state_q == WR_REQ ? dst_q[grant_q] : '0;
  assign m_wdata  = state_q == WR_REQ ? word_q : '0;
  // round-robin search for the next busy channel starting after the last grant
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CW'((int'(last_q) + k) % NUM_CH);
      if (!found && busy_q[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end
  // engine FSM: one word read then written per grant
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    word_d    = word_q;
    xfer_done = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        grant_d = pick;
        last_d  = pick;
        state_d = RD_REQ;
      end
      RD_REQ: state_d = m_ready ? RD_WAIT : RD_REQ;
      RD_WAIT: if (m_rvalid) begin
        word_d  = m_rdata;
        state_d = WR_REQ;
      end
      WR_REQ: if (m_ready) begin
        xfer_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // register writes first, hardware updates last so a hardware set beats a same-cycle W1C
  always_comb begin
    ien_d  = ien_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d  = err_q;
    src_d  = src_q;
    dst_d  = dst_q;
    len_d  = len_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr && ch_w == 12'(i)) begin
        case (off_w)
          12'h00: begin
            ien_d[i] = s_wdata[1];
            if (s_wdata[0] && !busy_q[i]) begin
              if (len_q[i] == '0) done_d[i] = 1'b1;
              else if (|{src_q[i][2:0], dst_q[i][2:0], len_q[i][2:0]}) err_d[i] = 1'b1;
              else begin
                busy_d[i] = 1'b1;
                done_d[i] = 1'b0;
                err_d[i]  = 1'b0;
              end
            end
          end
          12'h08: begin
            done_d[i] = done_q[i] & ~s_wdata[1];
            err_d[i]  = err_q[i] & ~s_wdata[2];
          end
          12'h10: src_d[i] = busy_q[i] ? src_q[i] : s_wdata;
          12'h18: dst_d[i] = busy_q[i] ? dst_q[i] : s_wdata;
          12'h20: len_d[i] = busy_q[i] ? len_q[i] : s_wdata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
    end
    if (xfer_done) begin
      src_d[grant_q] = src_q[grant_q] + 64'd8;
      dst_d[grant_q] = dst_q[grant_q] + 64'd8;
      len_d[grant_q] = len_q[grant_q] - LEN_WIDTH'(8);
      if (len_q[grant_q] == LEN_WIDTH'(8)) begin
        busy_d[grant_q] = 1'b0;
        done_d[grant_q] = 1'b1;
      end
    end
  end
  // register-bus read mux; unmapped offsets and absent channels return zero
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_w == 12'(i)) begin
        case (off_w)
          12'h00: rdata_d = {62'd0, ien_q[i], 1'b0};
          12'h08: rdata_d = {61'd0, err_q[i], done_q[i], busy_q[i]};
          12'h10: rdata_d = src_q[i];
          12'h18: rdata_d = dst_q[i];
          12'h20: rdata_d = 64'(len_q[i]);
          default: rdata_d = '0;
        endcase
      end
    end
  end
  // state registers, read response and registered interrupts
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= CW'(NUM_CH - 1);
      word_q   <= '0;
      ien_q    <= '0;
      busy_q   <= '0;
      done_q   <= '0;
      err_q    <= '0;
      irq_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i] <= '0;
        dst_q[i] <= '0;
        len_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      word_q   <= word_d;
      ien_q    <= ien_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= ien_q & (done_q | err_q);
      rvalid_q <= s_valid && !s_wen;
      rdata_q  <= (s_valid && !s_wen) ? rdata_d : '0;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
    end
  end
endmodule

// File: doc/dma_multi_ch.md
DMA_MULTI_CH -- requirements
Module: dma_multi_ch

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_CH, 4, number of independent DMA channels (1..8)
  CH_STRIDE, 'h40, byte stride between channel register blocks
  LEN_WIDTH, 32, width of the per-channel byte-count register
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock; all logic on rising edge
  rst  in  1  synchronous, active-high reset
  s_valid  in  1  register-bus request valid
  s_ready  out  1  register-bus request accepted
  s_addr  in  12  byte offset within the DMA window (MMAP_DMA_BEGIN-relative)
  s_wen  in  1  1 = write, 0 = read
  s_wdata  in  64  write data
  s_rvalid  out  1  read data valid
  s_rdata  out  64  read data
  m_valid  out  1  memory request valid
  m_ready  in  1  memory request accepted
  m_addr  out  64  memory byte address (8-byte aligned)
  m_wen  out  1  1 = write, 0 = read
  m_wdata  out  64  memory write data
  m_rvalid  in  1  memory read data valid
  m_rdata  in  64  memory read data
  irq  out  NUM_CH  per-channel interrupt, level
REQ-003 One clock (clk); reset rst is synchronous and active-high.

Function
REQ-004 Channel i's registers SHALL sit at offset i*CH_STRIDE: CTRL +'h00, STATUS +'h08, SRC +'h10 (64b), DST +'h18 (64b), LEN +'h20 (LEN_WIDTH, zero-extended on read).
REQ-005 CTRL SHALL be bit0 START (write-1 pulse, reads 0) and bit1 IRQ_EN (R/W); STATUS SHALL be bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C).
REQ-006 s_ready SHALL be constantly 1; an accepted read SHALL yield s_rvalid=1 with s_rdata exactly one cycle later; unmapped offsets and channels >= NUM_CH SHALL read 0 and ignore writes.
REQ-007 Writes to SRC/DST/LEN while that channel's BUSY=1 SHALL be ignored; reads SHALL return live values (SRC/DST advance, LEN counts down).
REQ-008 START with BUSY=0: if LEN=0, set DONE next cycle with no memory traffic; else if SRC[2:0], DST[2:0] or LEN[2:0] nonzero, set ERR next cycle with no traffic; else set BUSY and clear DONE/ERR.
REQ-009 START while BUSY=1 SHALL be ignored.
REQ-010 A single engine FSM SHALL have states IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-011 IDLE: if any channel BUSY, grant one by round-robin (search from last_grant+1 modulo NUM_CH; last_grant resets to NUM_CH-1), go RD_REQ; else stay.
REQ-012 RD_REQ: m_valid=1, m_wen=0, m_addr=SRC of granted channel; on m_ready go RD_WAIT.
REQ-013 RD_WAIT: m_valid=0; on m_rvalid capture m_rdata, go WR_REQ.
REQ-014 WR_REQ: m_valid=1, m_wen=1, m_addr=DST, m_wdata=captured word; on m_ready: SRC+=8, DST+=8, LEN-=8; if new LEN=0 clear BUSY and set DONE; go IDLE.
REQ-015 One 8-byte word SHALL be moved per grant, so active channels interleave word-by-word.
REQ-016 m_addr/m_wen/m_wdata SHALL stay stable while m_valid=1 and m_ready=0.
REQ-017 SRC/DST SHALL wrap modulo 2^64 without error.
REQ-018 If DONE/ERR is set by hardware and cleared by a W1C write in the same cycle, set SHALL win.
REQ-019 irq[i] SHALL equal IRQ_EN[i] & (DONE[i] | ERR[i]), registered, one cycle after the status change.

Reset
REQ-020 While rst=1 at a clock edge: FSM to IDLE; all CTRL/STATUS/SRC/DST/LEN to 0; last_grant to NUM_CH-1; s_rvalid, m_valid, m_wen, irq to 0; s_rdata, m_addr, m_wdata to 0.
REQ-021 Reset mid-transfer SHALL abort all channels; m_valid SHALL be 0 from the first cycle after the reset edge, and any late m_rvalid SHALL be ignored.

Verification
REQ-022 Ch0 SRC='h8000_0000, DST='h8000_1000, LEN=24, IRQ_EN=1, START; memory m_ready=1, rvalid 2 cycles after read -> 3 reads then 3 writes interleaved, DST words equal SRC words, DONE=1, LEN=0, irq[0]=1.
REQ-023 Ch1 and ch2 both LEN=16, started same cycle -> grant order 1,2,1,2; both DONE.
REQ-024 Ch3 LEN=0 START -> DONE=1 next cycle, m_valid never asserted; ch0 SRC='h8000_0004 -> ERR=1, no traffic.
REQ-025 m_ready held 0 for 5 cycles in RD_REQ -> m_addr/m_wen constant throughout; START to busy channel ignored; SRC write while BUSY ignored.
REQ-026 rst=1 during WR_REQ -> next cycle m_valid=0, all STATUS=0, irq=0; W1C of DONE in the completion cycle -> DONE stays 1.
